sha256_msg_scheduler: RTL and testbench

//  Registered SHA-256 message-schedule expander (FIPS 180-4 §6.2.2 step 1).

---
 rtl/sha256_msg_scheduler.sv | 77 +++++++
 tb/tb_sha256_msg_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_scheduler.sv
// sha256_msg_scheduler
//   Registered SHA-256 message-schedule expander. One 512-bit padded block in,
//   all 64 schedule words out on a single 2048-bit bus, one cycle later.
//
// Parameters
//   BYTE_SWAP  0 = big-endian block words (standard)
//              1 = reverse the 4 bytes of each input word (little-endian source)
//
// Ports
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   valid_in   in   1     data_in carries a block this cycle
//   data_in    in   512   padded block, first message byte in [511:504]
//   words      out  2048  W[i] = words[32*i +: 32], i = 0..63
//   valid_out  out  1     words holds the schedule of last cycle's block
//
// Build option
//   SHA256_MSGSCHED_CLEAR_EN  when defined, the words register is scrubbed to 0
//                             on every edge without valid_in; otherwise it holds.
module sha256_msg_scheduler #(
  parameter int BYTE_SWAP = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  logic [511:0]  data_in,
  output logic [2047:0] words,
  output logic          valid_out
);

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  logic [2047:0] words_next;

  // Each generate iteration owns one schedule word so the chain is a plain
  // feed-forward net with no self-referencing vector.
  for (genvar t = 0; t < 64; t++) begin : g_w
    logic [31:0] w;
    if (t < 16) begin : g_in
      logic [31:0] raw;
      assign raw = data_in[511-32*t -: 32];
      if (BYTE_SWAP != 0) begin : g_swap
        assign w = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
      end else begin : g_noswap
        assign w = raw;
      end
    end else begin : g_exp
      // 32-bit sum: carries out of bit 31 drop naturally.
      assign w = sig1(g_w[t-2].w) + g_w[t-7].w + sig0(g_w[t-15].w) + g_w[t-16].w;
    end
    assign words_next[32*t +: 32] = w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        words <= words_next;
      end
`ifdef SHA256_MSGSCHED_CLEAR_EN
      else begin
        words <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Testbench for sha256_msg_scheduler: two instances (BYTE_SWAP 0 and 1) share
// the stimulus and are compared word by word against a reference model of the
// SHA-256 message schedule.
module tb_sha256_msg_scheduler;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [511:0]  data_in = '0;
  logic [2047:0] words0, words1;
  logic          vo0, vo1;

  logic [2047:0] exp0 = '0, exp1 = '0;
  logic          exp_v = 1'b0;

  int checks = 0;
  int errors = 0;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};

  always #5 clk = ~clk;

  sha256_msg_scheduler #(.BYTE_SWAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .words(words0), .valid_out(vo0)
  );

  sha256_msg_scheduler #(.BYTE_SWAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .words(words1), .valid_out(vo1)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [2047:0] sched(input logic [511:0] blk, input bit swap);
    logic [31:0]   wv [64];
    logic [31:0]   x, s0, s1;
    logic [2047:0] r;
    for (int t = 0; t < 16; t++) begin
      x = blk[511-32*t -: 32];
      if (swap) x = {x[7:0], x[15:8], x[23:16], x[31:24]};
      wv[t] = x;
    end
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(wv[t-15], 7) ^ rotr(wv[t-15], 18) ^ (wv[t-15] >> 3);
      s1 = rotr(wv[t-2], 17) ^ rotr(wv[t-2], 19) ^ (wv[t-2] >> 10);
      wv[t] = 32'((64'(s1) + 64'(wv[t-7]) + 64'(s0) + 64'(wv[t-16])) % 64'h1_0000_0000);
    end
    for (int t = 0; t < 64; t++) r[32*t +: 32] = wv[t];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " valid0"}, {31'b0, vo0}, {31'b0, exp_v});
    check({tag, " valid1"}, {31'b0, vo1}, {31'b0, exp_v});
    for (int i = 0; i < 64; i++) begin
      check($sformatf("%s bs0 W%0d", tag, i), words0[32*i +: 32], exp0[32*i +: 32]);
      check($sformatf("%s bs1 W%0d", tag, i), words1[32*i +: 32], exp1[32*i +: 32]);
    end
  endtask

  // Drive one cycle from the falling edge, update the model at the rising
  // edge, and leave the caller at the next falling edge for sampling.
  task automatic step(input logic v, input logic [511:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    exp_v = v;
    if (v) begin
      exp0 = sched(d, 1'b0);
      exp1 = sched(d, 1'b1);
    end else begin
`ifdef SHA256_MSGSCHED_CLEAR_EN
      exp0 = '0;
      exp1 = '0;
`endif
    end
    @(negedge clk);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    logic [511:0] blk;
    logic         v;

    // Reset state with no clock edge yet.
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // "abc" block.
    step(1'b1, BLK_ABC);
    check_all("abc");
    check("abc W0",  words0[32*0  +: 32], 32'h61626380);
    check("abc W15", words0[32*15 +: 32], 32'h00000018);
    check("abc W16", words0[32*16 +: 32], 32'h61626380);
    check("abc W17", words0[32*17 +: 32], 32'h000F0000);

    // Idle for three cycles: hold or scrub depending on the build.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, rand_block());
      check_all("idle");
    end
`ifdef SHA256_MSGSCHED_CLEAR_EN
    check("idle W16", words0[32*16 +: 32], 32'h00000000);
`else
    check("idle W16", words0[32*16 +: 32], 32'h61626380);
`endif

    // Empty-string block.
    step(1'b1, BLK_EMPTY);
    check_all("empty");
    check("empty W0",  words0[32*0  +: 32], 32'h80000000);
    check("empty W16", words0[32*16 +: 32], 32'h80000000);
    check("empty W17", words0[32*17 +: 32], 32'h00000000);

    // Back-to-back blocks, then valid drops.
    step(1'b1, BLK_ABC);
    check_all("b2b abc");
    step(1'b1, BLK_EMPTY);
    check_all("b2b empty");
    step(1'b0, '0);
    check_all("b2b drop");

    // data_in changes after the sampling edge must not affect words.
    valid_in = 1'b1;
    data_in  = BLK_ABC;
    @(posedge clk);
    exp_v = 1'b1;
    exp0  = sched(BLK_ABC, 1'b0);
    exp1  = sched(BLK_ABC, 1'b1);
    #2 data_in = rand_block();
    @(negedge clk);
    check_all("sample edge");

    // Asynchronous reset in the middle of a stream.
    step(1'b1, rand_block());
    check_all("pre rst");
    #2 rst_n = 1'b0;
    #1;
    exp_v = 1'b0;
    exp0  = '0;
    exp1  = '0;
    check_all("async rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, BLK_EMPTY);
    check_all("post rst");

    // Random traffic with random gaps.
    for (int n = 0; n < 1000; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      blk = rand_block();
      step(v, blk);
      check_all("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
